countdown_timer_c: RTL

- Loadable down-counter with expiry handshake. It is the decrementing counterpart of the team's up-counting counter_c.
- Serves as the timebase for watchdogs, delay slots and periodic events in the core.
- Counts a loaded value down to zero and raises a one-cycle expiry pulse plus a sticky pending flag, which the consumer clears with an acknowledge.
- Optionally reloads itself for periodic operation.

---
 rtl/countdown_timer_c.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_c.sv
// rtl/countdown_timer_c.sv - loadable down-counter with expiry pulse, sticky pending flag and optional auto-reload
//
// Purpose:
//   Timebase for watchdogs, delay slots and periodic events. A loaded value
//   counts down to zero. Reaching zero raises a one-cycle expired pulse and
//   sets a sticky pending flag that the consumer clears with ack. With
//   auto_reload the count restarts from the last loaded value.
//
// Optional feature macro: COUNTDOWN_TIMER_PRESCALER_EN
//   When this macro is defined, the prescale port is added. Counting then
//   advances once every prescale+1 enabled cycles. When the macro is not
//   defined, every enabled cycle is a tick.
//
// Ports:
//   inner_clk      in   clock, all state updates on posedge
//   reset          in   synchronous, active-high
//   enable         in   count enable; count, state and prescaler hold when low
//   load           in   load D_IN into count and reload register (beats tick)
//   D_IN           in   load value
//   auto_reload    in   sampled at expiry: 1 = reload and keep running, 0 = stop
//   ack            in   clears pending (a same-cycle expiry wins)
//   prescale       in   tick every prescale+1 enabled cycles (prescaler build only)
//   D_OUT          out  current count (registered)
//   running        out  timer is actively counting
//   expired        out  registered one-cycle pulse after the count reaches 0
//   pending        out  sticky expiry flag
//   will_underflow out  combinational: running & tick & D_OUT == 1

module countdown_timer_c #(
  parameter int word_width     = 8,
  parameter int prescale_width = 4
) (
  input  logic                      inner_clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [word_width-1:0]     D_IN,
  input  logic                      auto_reload,
  input  logic                      ack,
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
  input  logic [prescale_width-1:0] prescale,
`endif
  output logic [word_width-1:0]     D_OUT,
  output logic                      running,
  output logic                      expired,
  output logic                      pending,
  output logic                      will_underflow
);

  // Reject parameter values the datapath cannot support at elaboration.
  if (word_width < 2) begin : g_bad_word_width
    $error("countdown_timer_c: word_width must be at least 2");
  end
  if (prescale_width < 1) begin : g_bad_prescale_width
    $error("countdown_timer_c: prescale_width must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // nothing loaded, or a zero was loaded
    ST_RUN  = 2'd1,   // decrementing on each tick
    ST_DONE = 2'd2    // expired without auto-reload, count parked at 0
  } state_t;

  localparam logic [word_width-1:0] count_zero = '0;
  localparam logic [word_width-1:0] count_one  = {{(word_width-1){1'b0}}, 1'b1};

  state_t                  state_q, state_nxt;
  logic [word_width-1:0]   count_q, count_nxt;
  logic [word_width-1:0]   reload_q, reload_nxt;
  logic                    expired_q, expired_nxt;
  logic                    pending_q, pending_nxt;
  logic                    tick;

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
  // Prescaler: counts enabled RUN cycles. A tick fires on the cycle in which
  // the count equals prescale, so prescale is compared live. A change to
  // prescale therefore takes effect at the next compare.
  logic [prescale_width-1:0] psc_q, psc_nxt;
  logic                      psc_hit;

  assign psc_hit = (psc_q == prescale);
  assign tick    = enable & psc_hit;

  always_comb begin
    psc_nxt = psc_q;
    if (load) begin
      psc_nxt = '0;
    end else if (state_q != ST_RUN) begin
      psc_nxt = '0;
    end else if (enable) begin
      if (psc_hit) begin
        psc_nxt = '0;
      end else begin
        psc_nxt = psc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge inner_clk) begin
    if (reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_nxt;
    end
  end
`else
  assign tick = enable;
`endif

  // Next-state and datapath decode. The priority order is load > tick > hold.
  // ack only touches pending, so it sits outside that chain.
  always_comb begin
    state_nxt   = state_q;
    count_nxt   = count_q;
    reload_nxt  = reload_q;
    expired_nxt = 1'b0;
    pending_nxt = pending_q & ~ack;

    if (load) begin
      count_nxt  = D_IN;
      reload_nxt = D_IN;
      state_nxt  = (D_IN != count_zero) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            if (count_q == count_one) begin
              // Expiry. Setting pending here overrides a same-cycle ack.
              expired_nxt = 1'b1;
              pending_nxt = 1'b1;
              if (auto_reload) begin
                count_nxt = reload_q;
              end else begin
                count_nxt = count_zero;
                state_nxt = ST_DONE;
              end
            end else if (count_q != count_zero) begin
              count_nxt = count_q - count_one;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // Parked. Only load or reset can leave these states.
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge inner_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      count_q   <= count_nxt;
      reload_q  <= reload_nxt;
      expired_q <= expired_nxt;
      pending_q <= pending_nxt;
    end
  end

  assign D_OUT          = count_q;
  assign running        = (state_q == ST_RUN);
  assign expired        = expired_q;
  assign pending        = pending_q;
  assign will_underflow = running & tick & (count_q == count_one);

endmodule
